// File: rtl/data_mem_slave_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_slave_pkg;

    localparam int unsigned REG_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef logic [REG_W-1:0] reg_bus_t;

    localparam reg_bus_t ZERO_WORD     = '0;
    localparam logic     RST_ENABLE    = 1'b1;
    localparam logic     CHIP_ENABLE   = 1'b1;
    localparam logic     CHIP_DISABLE  = 1'b0;
    localparam logic     WRITE_ENABLE  = 1'b1;
    localparam logic     WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    typedef struct packed {
        logic             we;
        reg_bus_t         addr;
        logic [SEL_W-1:0] sel;
        reg_bus_t         data;
    } mem_req_t;

    // A request is rejected when it addresses beyond the array or selects no lanes.
    function automatic logic req_error(input reg_bus_t addr, input logic [SEL_W-1:0] sel,
                                       input int unsigned addr_width);
        return ((addr >> (addr_width + 2)) != ZERO_WORD) || (sel == '0);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with byte write enables and a lane-masked registered read.
module data_mem_array
    import data_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [SEL_W-1:0]      wr_be,
    input  reg_bus_t              wr_data,
    input  logic [SEL_W-1:0]      rd_lane,
    output reg_bus_t              rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    reg_bus_t mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < int'(SEL_W); b++) begin
                if (wr_be[b]) begin
                    mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read register doubles as the load-data output; it holds until the next access.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rd_data <= ZERO_WORD;
        end else if (en) begin
            for (int b = 0; b < int'(SEL_W); b++) begin
                rd_data[8*b +: 8] <= rd_lane[b] ? mem[addr][8*b +: 8] : 8'h00;
            end
        end
    end

endmodule

// File: rtl/data_mem_slave.sv
// Load/store responder for the MEM stage: wait-state insertion, range/lane check, byte-laned RAM access.
module data_mem_slave
    import data_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [REG_W-1:0]  mem_addr_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [REG_W-1:0]  mem_data_i,
    output logic [REG_W-1:0]  mem_data_o,
    output logic              mem_ack_o,
    output logic              mem_err_o,
    output logic              busy_o
);

    state_e                state;
    logic [CNT_W-1:0]      wait_cnt;
    mem_req_t              req_q;
    mem_req_t              live_req;
    mem_req_t              acc_req;
    logic                  acc_fire;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_word;
    logic [SEL_W-1:0]      wr_be;
    logic [SEL_W-1:0]      rd_lane;

    // With zero wait states the access edge is the acceptance edge, so the live request is used.
    always_comb begin
        live_req = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, data: mem_data_i};
        acc_req  = (state == ST_IDLE) ? live_req : req_q;
        acc_err  = req_error(acc_req.addr, acc_req.sel, ADDR_WIDTH);
        acc_word = ADDR_WIDTH'(acc_req.addr >> 2);
        acc_fire = 1'b0;
        if (rst != RST_ENABLE) begin
            case (state)
                ST_IDLE: acc_fire = (mem_ce_i == CHIP_ENABLE) && (WAIT_CYCLES == 0);
                ST_WAIT: acc_fire = (wait_cnt == '0);
                default: acc_fire = 1'b0;
            endcase
        end
        wr_be   = (!acc_err && acc_req.we == WRITE_ENABLE)  ? acc_req.sel : '0;
        rd_lane = (!acc_err && acc_req.we == WRITE_DISABLE) ? acc_req.sel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_q     <= '0;
            mem_ack_o <= 1'b0;
            mem_err_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_ack_o <= 1'b0;
                    mem_err_o <= 1'b0;
                    if (mem_ce_i != CHIP_DISABLE) begin
                        req_q  <= live_req;
                        busy_o <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state     <= ST_ACK;
                            mem_ack_o <= 1'b1;
                            mem_err_o <= acc_err;
                        end else begin
                            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_ACK;
                        mem_ack_o <= 1'b1;
                        mem_err_o <= acc_err;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    state     <= ST_IDLE;
                    mem_ack_o <= 1'b0;
                    mem_err_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_ack_o <= 1'b0;
                    mem_err_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

    data_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .en     (acc_fire),
        .addr   (acc_word),
        .wr_be  (wr_be),
        .wr_data(acc_req.data),
        .rd_lane(rd_lane),
        .rd_data(mem_data_o)
    );

endmodule

// File: tb/tb_data_mem_slave.sv
// Scoreboarded directed bench: one responder with two wait states, one with none.
module tb_data_mem_slave;

    localparam int unsigned WC_A = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_e;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_a, we_a, ack_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  sel_a;
    logic        ce_b, we_b, ack_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  sel_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    data_mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC_A)) dut_a (
        .clk(clk), .rst(rst), .mem_ce_i(ce_a), .mem_we_i(we_a), .mem_addr_i(addr_a),
        .mem_sel_i(sel_a), .mem_data_i(wdata_a), .mem_data_o(rdata_a),
        .mem_ack_o(ack_a), .mem_err_o(err_a), .busy_o(busy_a)
    );

    data_mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .mem_ce_i(ce_b), .mem_we_i(we_b), .mem_addr_i(addr_b),
        .mem_sel_i(sel_b), .mem_data_i(wdata_b), .mem_data_o(rdata_b),
        .mem_ack_o(ack_b), .mem_err_o(err_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one request to dut_a, hold ce until ack, optionally scramble inputs while waiting.
    task automatic req_a(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e,
                         input bit scramble, input string tag);
        exp_t e;
        int   cyc;
        sb_q.push_back('{d: exp_d, e: exp_e});
        @(negedge clk);
        ce_a = 1'b1; we_a = we; addr_a = addr; sel_a = sel; wdata_a = data;
        @(negedge clk);
        if (scramble) begin
            addr_a = addr ^ 32'h0000_0FF0; wdata_a = ~data; sel_a = ~sel; we_a = ~we;
        end
        cyc = 0;
        while (ack_a !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(WC_A));
        e = sb_q.pop_front();
        chk({tag, " data"}, rdata_a, e.d);
        chk({tag, " err"}, 32'(err_a), 32'(e.e));
        chk({tag, " busy@ack"}, 32'(busy_a), 32'd1);
        ce_a = 1'b0;
        @(negedge clk);
        chk({tag, " ack drop"}, 32'(ack_a), 32'd0);
        chk({tag, " busy drop"}, 32'(busy_a), 32'd0);
        chk({tag, " data hold"}, rdata_a, e.d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t b_list[$];
        exp_t  e;

        rst = 1'b1;
        ce_a = 0; we_a = 0; addr_a = '0; sel_a = '0; wdata_a = '0;
        ce_b = 0; we_b = 0; addr_b = '0; sel_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        chk("rst ack_a", 32'(ack_a), 32'd0);
        chk("rst err_a", 32'(err_a), 32'd0);
        chk("rst busy_a", 32'(busy_a), 32'd0);
        chk("rst data_a", rdata_a, 32'd0);
        chk("rst ack_b", 32'(ack_b), 32'd0);
        chk("rst data_b", rdata_b, 32'd0);
        rst = 1'b0;

        // Basic store/load
        req_a(1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, "st 0x10");
        req_a(0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, "ld 0x10");
        // Byte lanes
        req_a(1, 32'h20, 4'b1111, 32'h11223344, 32'h0, 0, 0, "st 0x20 full");
        req_a(1, 32'h20, 4'b0100, 32'hAABBCCDD, 32'h0, 0, 0, "st 0x20 lane2");
        req_a(0, 32'h20, 4'b1111, 32'h0, 32'h11BB3344, 0, 0, "ld 0x20 full");
        req_a(0, 32'h20, 4'b0011, 32'h0, 32'h00003344, 0, 0, "ld 0x20 low");
        // Out of range and empty lane select
        req_a(1, 32'h0, 4'b1111, 32'h0BADF00D, 32'h0, 0, 0, "st 0x0");
        req_a(1, 32'hFFC, 4'b1111, 32'h5A5A5A5A, 32'h0, 0, 0, "st 0xFFC");
        req_a(1, 32'h1000, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, 0, "st 0x1000 err");
        req_a(1, 32'h1FFC, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, 0, "st 0x1FFC err");
        req_a(0, 32'h0, 4'b1111, 32'h0, 32'h0BADF00D, 0, 0, "ld 0x0");
        req_a(0, 32'hFFC, 4'b1111, 32'h0, 32'h5A5A5A5A, 0, 0, "ld 0xFFC");
        req_a(0, 32'h10, 4'b0000, 32'h0, 32'h0, 1, 0, "ld sel0 err");
        req_a(1, 32'h10, 4'b0000, 32'h12121212, 32'h0, 1, 0, "st sel0 err");
        req_a(0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, "ld 0x10 after sel0");
        req_a(0, 32'h8000_0010, 4'b1111, 32'h0, 32'h0, 1, 0, "ld high err");
        // Inputs disturbed while waiting
        req_a(1, 32'h30, 4'b1111, 32'h13579BDF, 32'h0, 0, 1, "st 0x30 scrambled");
        req_a(0, 32'h30, 4'b1111, 32'h0, 32'h13579BDF, 0, 1, "ld 0x30 scrambled");

        // Reset arriving on the access edge of a store
        req_a(1, 32'h40, 4'b1111, 32'h12345678, 32'h0, 0, 0, "st 0x40");
        req_a(0, 32'h40, 4'b1111, 32'h0, 32'h12345678, 0, 0, "ld 0x40");
        @(negedge clk);
        ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; sel_a = 4'b1111; wdata_a = 32'h87654321;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ce_a = 1'b0;
        chk("abort ack", 32'(ack_a), 32'd0);
        chk("abort err", 32'(err_a), 32'd0);
        chk("abort busy", 32'(busy_a), 32'd0);
        chk("abort data", rdata_a, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort no ack", 32'(ack_a), 32'd0);
        end
        req_a(0, 32'h40, 4'b1111, 32'h0, 32'h12345678, 0, 0, "ld 0x40 after abort");

        // Zero wait states, ce held continuously
        b_list.push_back('{1, 32'h0,    4'b1111, 32'h01020304, 32'h0,        0});
        b_list.push_back('{0, 32'h0,    4'b1111, 32'h0,        32'h01020304, 0});
        b_list.push_back('{1, 32'h104,  4'b1111, 32'hCAFEF00D, 32'h0,        0});
        b_list.push_back('{0, 32'h104,  4'b0110, 32'h0,        32'h00FEF000, 0});
        b_list.push_back('{1, 32'h1000, 4'b1111, 32'h00000001, 32'h0,        1});
        b_list.push_back('{0, 32'h0,    4'b1111, 32'h0,        32'h01020304, 0});
        b_list.push_back('{0, 32'h104,  4'b0000, 32'h0,        32'h0,        1});
        b_list.push_back('{0, 32'h104,  4'b1111, 32'h0,        32'hCAFEF00D, 0});

        @(negedge clk);
        ce_b = 1'b1; we_b = b_list[0].we; addr_b = b_list[0].addr;
        sel_b = b_list[0].sel; wdata_b = b_list[0].data;
        sb_q.push_back('{d: b_list[0].exp_d, e: b_list[0].exp_e});
        for (int i = 0; i < b_list.size(); i++) begin
            @(negedge clk);
            chk($sformatf("b%0d ack", i), 32'(ack_b), 32'd1);
            chk($sformatf("b%0d busy@ack", i), 32'(busy_b), 32'd1);
            e = sb_q.pop_front();
            chk($sformatf("b%0d data", i), rdata_b, e.d);
            chk($sformatf("b%0d err", i), 32'(err_b), 32'(e.e));
            if (i + 1 < b_list.size()) begin
                we_b = b_list[i+1].we; addr_b = b_list[i+1].addr;
                sel_b = b_list[i+1].sel; wdata_b = b_list[i+1].data;
                sb_q.push_back('{d: b_list[i+1].exp_d, e: b_list[i+1].exp_e});
            end else begin
                ce_b = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b%0d idle ack", i), 32'(ack_b), 32'd0);
            chk($sformatf("b%0d idle busy", i), 32'(busy_b), 32'd0);
        end
        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
